mod_updown_counter: RTL and testbench
=====================================

// Module: mod_updown_counter
// PURPOSE
//  Parametrised modulo-N up/down counter: async active-low reset, sync clear, parallel load,
//  enable and direction. Step prescaler, wrap/saturate mode, terminal-count, wrap-pulse and
//  sticky-overflow flags. Successor to the fixed 4-bit loadable counter. Used as a timer and
//  event-count primitive across the design.
// PARAMETERS
//  WIDTH     4   count/load_val width in bits
//  MODULO    16  counting range 0..MODULO-1; legal 2 <= MODULO <= 2**WIDTH
//  PRESCALE  1   enabled cycles per count step; legal >= 1 (1 = step every enabled cycle)
//  Illegal values -> $fatal at elaboration.
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      asynchronous, active-low reset (0 = reset)
//  clr       in   1      sync clear: count, prescaler and ovf to 0
//  load      in   1      sync parallel load of load_val
//  load_val  in   WIDTH  value for load
//  en        in   1      count enable; also gates the prescaler
//  dir       in   1      1 = up, 0 = down
//  sat       in   1      1 = saturate at range ends, 0 = wrap
//  count     out  WIDTH  current count (registered)
//  tc        out  1      terminal count (combinational): up & count==MODULO-1, or down & count==0
//  wrap      out  1      registered 1-cycle pulse, high in the cycle after a wrap step
//  ovf       out  1      sticky flag, set on any step attempted at a range end; cleared by clr/rst
// BEHAVIOUR
//  - rst=0 (async, independent of clk): count=0, pre_cnt=0, wrap=0, ovf=0.
//    rst deassertion is synchronised to clk at system level.
//  - Per-edge priority: clr > load > step > hold.
//  - clr: count=0, pre_cnt=0, ovf=0, wrap=0.
//  - load: count = (load_val >= MODULO) ? MODULO-1 : load_val; pre_cnt=0. ovf unchanged. wrap=0.
//  - Prescaler: pre_cnt advances only while en=1 (no clr/load) and holds while en=0.
//    tick = en & (pre_cnt==PRESCALE-1); pre_cnt returns to 0 on tick.
//  - Step (tick=1):
//      up, count<MODULO-1    -> count+1
//      up, count==MODULO-1   -> sat=0: count=0, wrap=1, ovf=1; sat=1: hold, ovf=1, wrap=0
//      down, count>0         -> count-1
//      down, count==0        -> sat=0: count=MODULO-1, wrap=1, ovf=1; sat=1: hold, ovf=1
//  - wrap is 0 in every cycle not immediately following a wrap step.
//  - dir/sat are sampled at the step edge. A change mid-prescale affects the next step only;
//    pre_cnt is not reset.
//  - Latency: load/clr/step visible on count one cycle after the sampling edge.
//    tc tracks count and dir combinationally.
//  - Arithmetic is modulo MODULO, not 2**WIDTH. count never holds a value >= MODULO.
//  - Reset asserted mid-prescale or mid-wrap-pulse: all state cleared immediately, no pulse emitted.
// STRUCTURE
//  - counter_pkg: typedef enum logic {DIR_DOWN=1'b0, DIR_UP=1'b1} count_dir_e;
//    typedef enum logic {MODE_WRAP=1'b0, MODE_SAT=1'b1} count_mode_e.
//  - Sub-module tick_prescaler #(PRESCALE): ports clk, rst, clr (clr|load), en, tick.
//    When PRESCALE==1 it reduces to tick=en.
//  - Top: one always_ff for count/wrap/ovf, plus combinational next-count and tc.
// TESTING (WIDTH=4, MODULO=10, PRESCALE=1 unless noted)
//  1. rst=0 mid-count at 7 -> count=0, wrap=0, ovf=0 before next clk edge;
//     rst=1, en=1, dir=1 -> count 1,2,3 on successive edges.
//  2. load_val=12, load=1 -> count=9 (clamped). Then en=1, dir=1, sat=0 -> count=0, tc was 1
//     at 9, wrap=1 one cycle, ovf=1.
//  3. count=0, dir=0, sat=1, en=1 for 3 cycles -> count stays 0, tc=1, wrap never 1, ovf=1;
//     clr -> ovf=0.
//  4. load=1 and clr=1 same edge, load_val=5 -> count=0. load=1 and en=1 at count=3,
//     load_val=6 -> count=6 (load beats step).
//  5. PRESCALE=3, en=1 for 9 cycles with a 2-cycle en=0 gap after cycle 4 -> count=3;
//     count holds during the gap.
//  6. dir flipped 1->0 at count=4 while stepping -> sequence 4,5,4,3; no wrap, ovf=0.

Source files
------------

// File: rtl/mod_updown_counter_pkg.sv
// Shared types for the modulo-N up/down counter: direction and end-of-range mode encodings.
package counter_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} count_dir_e;
    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} count_mode_e;

    // Width needed to hold a prescaler phase 0..prescale-1 (at least one bit).
    function automatic int unsigned pre_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/mod_updown_counter_tick_prescaler.sv
// Step prescaler: emits one tick every PRESCALE enabled cycles; phase holds while en is low.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned PW = pre_width(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    // With PRESCALE==1 PRE_LAST is 0 and pre_cnt stays 0, so tick collapses to en.
    assign tick = en & (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load, clear, prescaled stepping, wrap/saturate and status flags.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULO   = 16,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
        $fatal(1, "mod_updown_counter: WIDTH out of range");
    end
    if (MODULO < 2 || MODULO > (32'd1 << WIDTH)) begin : g_bad_modulo
        $fatal(1, "mod_updown_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $fatal(1, "mod_updown_counter: PRESCALE must be >= 1");
    end

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic             tick;
    logic             is_up;
    logic             is_sat;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             ovf_nxt;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr | load),
        .en   (en),
        .tick (tick)
    );

    assign is_up  = (count_dir_e'(dir) == DIR_UP);
    assign is_sat = (count_mode_e'(sat) == MODE_SAT);

    // tc doubles as the "step would leave the range" indicator.
    assign tc = is_up ? (count == CNT_MAX) : (count == '0);

    // Next state; priority clr > load > step > hold.
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        ovf_nxt   = ovf;
        if (clr) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (load) begin
            count_nxt = ({1'b0, load_val} >= MOD_EXT) ? CNT_MAX : load_val;
        end else if (tick) begin
            if (tc) begin
                ovf_nxt = 1'b1;
                if (!is_sat) begin
                    count_nxt = is_up ? '0 : CNT_MAX;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                count_nxt = is_up ? count + WIDTH'(1) : count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: directed scenarios plus random stimulus against a behavioural model.
module tb_mod_updown_counter;

    localparam int MOD = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic       sat = 1'b0;

    logic [3:0] count_a, count_b;
    logic       tc_a, tc_b, wrap_a, wrap_b, ovf_a, ovf_b;

    int total = 0;
    int bad   = 0;

    // Model state: a = PRESCALE 1, b = PRESCALE 3.
    int m_ca = 0, m_pa = 0, m_cb = 0, m_pb = 0;
    bit m_wa = 0, m_oa = 0, m_wb = 0, m_ob = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULO(MOD), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .sat(sat),
        .count(count_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
    );

    mod_updown_counter #(.WIDTH(4), .MODULO(MOD), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .sat(sat),
        .count(count_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
    );

    // Behavioural model of one clock edge, straight from the counting rules.
    task automatic model_edge(input int ps, inout int c, inout int p, inout bit w, inout bit o);
        bit w_n;
        w_n = 0;
        if (!rst) begin
            c = 0; p = 0; o = 0;
        end else if (clr) begin
            c = 0; p = 0; o = 0;
        end else if (load) begin
            c = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
            p = 0;
        end else if (en) begin
            if (p == ps - 1) begin
                p = 0;
                if (dir) begin
                    if (c < MOD - 1) c = c + 1;
                    else begin o = 1; if (!sat) begin c = 0; w_n = 1; end end
                end else begin
                    if (c > 0) c = c - 1;
                    else begin o = 1; if (!sat) begin c = MOD - 1; w_n = 1; end end
                end
            end else begin
                p = p + 1;
            end
        end
        w = w_n;
    endtask

    function automatic bit model_tc(input int c);
        return dir ? (c == MOD - 1) : (c == 0);
    endfunction

    task automatic model_reset();
        m_ca = 0; m_pa = 0; m_wa = 0; m_oa = 0;
        m_cb = 0; m_pb = 0; m_wb = 0; m_ob = 0;
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step_clk();
        @(posedge clk);
        model_edge(1, m_ca, m_pa, m_wa, m_oa);
        model_edge(3, m_cb, m_pb, m_wb, m_ob);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (count_a !== 4'd0 || wrap_a !== 1'b0 || ovf_a !== 1'b0) begin
            bad++; $display("FAIL reset_state: count=%0d wrap=%b ovf=%b, want 0/0/0", count_a, wrap_a, ovf_a);
        end
        step_clk();
        rst = 1'b1; en = 1'b1; dir = 1'b1; sat = 1'b0;
        repeat (7) step_clk();
        total++; if (count_a !== 4'd7) begin
            bad++; $display("FAIL reset_precount: count=%0d want 7", count_a);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        total++; if (count_a !== 4'd0 || wrap_a !== 1'b0 || ovf_a !== 1'b0 || count_b !== 4'd0) begin
            bad++; $display("FAIL reset_async: count=%0d wrap=%b ovf=%b count_b=%0d, want 0", count_a, wrap_a, ovf_a, count_b);
        end
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step_clk();
            total++; if (count_a !== 4'(i)) begin
                bad++; $display("FAIL reset_resume: count=%0d want %0d", count_a, i);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_clamp_wrap();
        dir = 1'b1; sat = 1'b0; en = 1'b0;
        load = 1'b1; load_val = 4'd12;
        step_clk();
        load = 1'b0;
        total++; if (count_a !== 4'd9 || tc_a !== 1'b1) begin
            bad++; $display("FAIL load_clamp: count=%0d tc=%b, want 9/1", count_a, tc_a);
        end
        en = 1'b1;
        step_clk();
        en = 1'b0;
        total++; if (count_a !== 4'd0 || wrap_a !== 1'b1 || ovf_a !== 1'b1) begin
            bad++; $display("FAIL wrap_up: count=%0d wrap=%b ovf=%b, want 0/1/1", count_a, wrap_a, ovf_a);
        end
        step_clk();
        total++; if (wrap_a !== 1'b0 || ovf_a !== 1'b1) begin
            bad++; $display("FAIL wrap_pulse_len: wrap=%b ovf=%b, want 0/1", wrap_a, ovf_a);
        end
    endtask

    task automatic test_sat_down();
        clr = 1'b1; step_clk(); clr = 1'b0;
        dir = 1'b0; sat = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            total++; if (count_a !== 4'd0 || tc_a !== 1'b1 || wrap_a !== 1'b0 || ovf_a !== 1'b1) begin
                bad++; $display("FAIL sat_down: count=%0d tc=%b wrap=%b ovf=%b, want 0/1/0/1", count_a, tc_a, wrap_a, ovf_a);
            end
        end
        en = 1'b0; clr = 1'b1; step_clk(); clr = 1'b0;
        total++; if (ovf_a !== 1'b0) begin
            bad++; $display("FAIL clr_ovf: ovf=%b want 0", ovf_a);
        end
    endtask

    task automatic test_priority();
        dir = 1'b1; sat = 1'b0; en = 1'b0;
        load = 1'b1; load_val = 4'd3; step_clk();
        load_val = 4'd5; clr = 1'b1; step_clk(); clr = 1'b0;
        total++; if (count_a !== 4'd0) begin
            bad++; $display("FAIL clr_beats_load: count=%0d want 0", count_a);
        end
        load_val = 4'd3; step_clk();
        load_val = 4'd6; en = 1'b1; step_clk();
        load = 1'b0; en = 1'b0;
        total++; if (count_a !== 4'd6) begin
            bad++; $display("FAIL load_beats_step: count=%0d want 6", count_a);
        end
    endtask

    task automatic test_prescale();
        dir = 1'b1; sat = 1'b0; en = 1'b0;
        clr = 1'b1; step_clk(); clr = 1'b0;
        en = 1'b1; repeat (4) step_clk();
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step_clk();
            total++; if (count_b !== 4'd1) begin
                bad++; $display("FAIL prescale_gap_hold: count=%0d want 1", count_b);
            end
        end
        en = 1'b1; repeat (5) step_clk();
        en = 1'b0;
        total++; if (count_b !== 4'd3) begin
            bad++; $display("FAIL prescale_count: count=%0d want 3", count_b);
        end
    endtask

    task automatic test_dir_flip();
        sat = 1'b0; en = 1'b0;
        clr = 1'b1; step_clk(); clr = 1'b0;
        load = 1'b1; load_val = 4'd4; step_clk(); load = 1'b0;
        en = 1'b1; dir = 1'b1; step_clk();
        total++; if (count_a !== 4'd5) begin
            bad++; $display("FAIL dir_flip_up: count=%0d want 5", count_a);
        end
        dir = 1'b0;
        for (int i = 4; i >= 3; i--) begin
            step_clk();
            total++; if (count_a !== 4'(i) || wrap_a !== 1'b0 || ovf_a !== 1'b0) begin
                bad++; $display("FAIL dir_flip_down: count=%0d wrap=%b ovf=%b, want %0d/0/0", count_a, wrap_a, ovf_a, i);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            clr      = ($urandom_range(0, 29) == 0);
            load     = ($urandom_range(0, 11) == 0);
            load_val = 4'($urandom_range(0, 15));
            en       = ($urandom_range(0, 3) != 0);
            dir      = 1'($urandom);
            sat      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0;
                model_reset();
                #1;
                total++; if (count_a !== 4'd0 || wrap_a !== 1'b0 || ovf_a !== 1'b0 || count_b !== 4'd0) begin
                    bad++; $display("FAIL rand_async_rst: count_a=%0d wrap=%b ovf=%b count_b=%0d", count_a, wrap_a, ovf_a, count_b);
                end
            end
            step_clk();
            rst = 1'b1;
            #1;
            total++;
            if (count_a !== 4'(m_ca) || tc_a !== model_tc(m_ca) || wrap_a !== m_wa || ovf_a !== m_oa) begin
                bad++; $display("FAIL rand_a[%0d]: count=%0d tc=%b wrap=%b ovf=%b, want %0d/%b/%b/%b",
                                n, count_a, tc_a, wrap_a, ovf_a, m_ca, model_tc(m_ca), m_wa, m_oa);
            end
            total++;
            if (count_b !== 4'(m_cb) || tc_b !== model_tc(m_cb) || wrap_b !== m_wb || ovf_b !== m_ob) begin
                bad++; $display("FAIL rand_b[%0d]: count=%0d tc=%b wrap=%b ovf=%b, want %0d/%b/%b/%b",
                                n, count_b, tc_b, wrap_b, ovf_b, m_cb, model_tc(m_cb), m_wb, m_ob);
            end
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_clamp_wrap();
        test_sat_down();
        test_priority();
        test_prescale();
        test_dir_flip();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
